// File: rtl/door_operator.sv
// door_operator -- elevator car door controller.
//
// Moore FSM (CLOSED, OPENING, OPEN_DWELL, CLOSING, FAULT). The motor commands,
// the move interlock and the fault flag are all decoded from the state register.
//
// Ports:
//   clk               rising-edge clock
//   reset             asynchronous, active-high; forces CLOSED, counters 0
//   door_open_req     open command from the elevator controller
//   motor_active      car is moving (motor_up | motor_down)
//   emergency         emergency indication; holds the door open
//   open_limit        door fully-open switch
//   closed_limit      door fully-closed switch
//   obstruction       light curtain broken
//   door_motor_open   drive the door toward open   (state == OPENING)
//   door_motor_close  drive the door toward closed (state == CLOSING)
//   door_closed_ok    car may move                 (state == CLOSED)
//   door_fault        fault latched                (state == FAULT)
//   state             3-bit state encoding for debug
//
// Timing: OPEN_DWELL lasts exactly DWELL_CYCLES cycles once the hold inputs
// drop, and OPENING/CLOSING fault after exactly TRAVEL_TIMEOUT cycles. Both
// counters therefore take their decision from the value the counter will hold
// after the current cycle is counted (dwell_dec / travel_inc).
module door_operator #(
    parameter int DWELL_CYCLES   = 16,
    parameter int TRAVEL_TIMEOUT = 64,
    parameter int REOPEN_LIMIT   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       door_open_req,
    input  logic       motor_active,
    input  logic       emergency,
    input  logic       open_limit,
    input  logic       closed_limit,
    input  logic       obstruction,
    output logic       door_motor_open,
    output logic       door_motor_close,
    output logic       door_closed_ok,
    output logic       door_fault,
    output logic [2:0] state
);

    localparam logic [2:0] S_CLOSED     = 3'd0;
    localparam logic [2:0] S_OPENING    = 3'd1;
    localparam logic [2:0] S_OPEN_DWELL = 3'd2;
    localparam logic [2:0] S_CLOSING    = 3'd3;
    localparam logic [2:0] S_FAULT      = 3'd4;

    // Counter widths, kept at least 1 bit so degenerate parameters still build.
    localparam int DW_RAW = $clog2(DWELL_CYCLES + 1);
    localparam int TW_RAW = $clog2(TRAVEL_TIMEOUT + 1);
    localparam int RW_RAW = $clog2(REOPEN_LIMIT + 1);
    localparam int DW = (DW_RAW > 0) ? DW_RAW : 1;
    localparam int TW = (TW_RAW > 0) ? TW_RAW : 1;
    localparam int RW = (RW_RAW > 0) ? RW_RAW : 1;

    localparam logic [DW-1:0] DWELL_LD   = DW'(DWELL_CYCLES);
    localparam logic [DW-1:0] DWELL_ONE  = DW'(1);
    localparam logic [TW-1:0] TRAVEL_MAX = TW'(TRAVEL_TIMEOUT);
    localparam logic [TW-1:0] TRAVEL_ONE = TW'(1);
    localparam logic [RW-1:0] REOPEN_MAX = RW'(REOPEN_LIMIT);
    localparam logic [RW-1:0] REOPEN_ONE = RW'(1);

    logic [2:0]    state_q, state_d;
    logic [DW-1:0] dwell_q, dwell_d, dwell_dec;
    logic [TW-1:0] travel_q, travel_d, travel_inc;
    logic [RW-1:0] reopen_q, reopen_d, reopen_inc;
    logic          travel_hit;
    logic          dwell_hold;

    always_comb begin
        // Saturating arithmetic: no counter is ever allowed to wrap.
        dwell_dec  = (dwell_q == '0) ? '0 : dwell_q - DWELL_ONE;
        travel_inc = (travel_q == TRAVEL_MAX) ? TRAVEL_MAX : travel_q + TRAVEL_ONE;
        reopen_inc = (reopen_q == REOPEN_MAX) ? REOPEN_MAX : reopen_q + REOPEN_ONE;
        travel_hit = (travel_inc == TRAVEL_MAX);
        dwell_hold = door_open_req | emergency | obstruction;

        state_d  = state_q;
        reopen_d = reopen_q;

        if (state_q != S_FAULT && open_limit && closed_limit) begin
            // Both limit switches at once means a broken sensor.
            state_d = S_FAULT;
        end else if (state_q != S_FAULT && state_q != S_CLOSED &&
                     door_open_req && motor_active) begin
            // Controller asking for an open while the car moves and the door
            // is not shut: interlock violation.
            state_d = S_FAULT;
        end else begin
            case (state_q)
                S_CLOSED: begin
                    if (door_open_req && !motor_active)
                        state_d = S_OPENING;
                    else if (!closed_limit && !door_open_req)
                        state_d = S_CLOSING;   // door drifted open: re-close
                end
                S_OPENING: begin
                    if (open_limit)
                        state_d = S_OPEN_DWELL;
                    else if (travel_hit)
                        state_d = S_FAULT;
                end
                S_OPEN_DWELL: begin
                    if (!dwell_hold && dwell_dec == '0)
                        state_d = S_CLOSING;
                end
                S_CLOSING: begin
                    if (closed_limit) begin
                        state_d  = S_CLOSED;
                        reopen_d = '0;
                    end else if (obstruction) begin
                        reopen_d = reopen_inc;
                        state_d  = (reopen_inc == REOPEN_MAX) ? S_FAULT : S_OPENING;
                    end else if (door_open_req || emergency) begin
                        state_d = S_OPENING;
                    end else if (travel_hit) begin
                        state_d = S_FAULT;
                    end
                end
                S_FAULT: state_d = S_FAULT;
                default: state_d = S_FAULT;   // illegal encoding
            endcase
        end

        // Travel counter restarts on every state change, so it is zero on
        // the first cycle of OPENING or CLOSING.
        if (state_d != state_q)
            travel_d = '0;
        else if (state_q == S_OPENING || state_q == S_CLOSING)
            travel_d = travel_inc;
        else
            travel_d = travel_q;

        if (state_d == S_OPEN_DWELL && state_q != S_OPEN_DWELL)
            dwell_d = DWELL_LD;
        else if (state_q == S_OPEN_DWELL)
            dwell_d = dwell_hold ? DWELL_LD : dwell_dec;
        else
            dwell_d = dwell_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_CLOSED;
            dwell_q  <= '0;
            travel_q <= '0;
            reopen_q <= '0;
        end else begin
            state_q  <= state_d;
            dwell_q  <= dwell_d;
            travel_q <= travel_d;
            reopen_q <= reopen_d;
        end
    end

    assign door_motor_open  = (state_q == S_OPENING);
    assign door_motor_close = (state_q == S_CLOSING);
    assign door_closed_ok   = (state_q == S_CLOSED);
    assign door_fault       = (state_q == S_FAULT);
    assign state            = state_q;

endmodule

// File: tb/tb_door_operator.sv
// Directed self-checking bench for door_operator (default parameters).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_door_operator;

    logic       clk = 1'b0;
    logic       reset;
    logic       door_open_req, motor_active, emergency;
    logic       open_limit, closed_limit, obstruction;
    logic       door_motor_open, door_motor_close, door_closed_ok, door_fault;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;
    logic bad;

    always #5 clk = ~clk;

    door_operator dut (
        .clk              (clk),
        .reset            (reset),
        .door_open_req    (door_open_req),
        .motor_active     (motor_active),
        .emergency        (emergency),
        .open_limit       (open_limit),
        .closed_limit     (closed_limit),
        .obstruction      (obstruction),
        .door_motor_open  (door_motor_open),
        .door_motor_close (door_motor_close),
        .door_closed_ok   (door_closed_ok),
        .door_fault       (door_fault),
        .state            (state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Synchronous-looking reset pulse with the door shut.
    task automatic do_reset();
        reset = 1'b1;
        door_open_req = 0; motor_active = 0; emergency = 0;
        open_limit = 0; closed_limit = 1; obstruction = 0;
        tick();
        reset = 1'b0;
    endtask

    // From CLOSED (closed_limit=1): open, reach the open limit and dwell out
    // the full 16 cycles; ends one tick into CLOSING with open_limit low.
    task automatic cycle_to_closing(input string tag);
        door_open_req = 1;
        tick();
        chk({tag, "_opening"}, state, 1);
        door_open_req = 0; closed_limit = 0; open_limit = 1;
        tick();
        chk({tag, "_dwell"}, state, 2);
        repeat (15) tick();
        chk({tag, "_dwell15"}, state, 2);
        open_limit = 0;
        tick();
        chk({tag, "_closing"}, state, 3);
    endtask

    initial begin
        reset = 1'b1;
        door_open_req = 0; motor_active = 0; emergency = 0;
        open_limit = 0; closed_limit = 1; obstruction = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", state, 0);
        chk("rst_closed_ok", door_closed_ok, 1);
        chk("rst_motors", {door_motor_open, door_motor_close}, 0);
        chk("rst_fault", door_fault, 0);
        reset = 1'b0;
        tick();
        chk("idle_closed", state, 0);

        // Normal cycle: one-cycle request, 10 cycles of travel, 16 dwell cycles.
        door_open_req = 1;
        tick();
        chk("norm_opening", state, 1);
        chk("norm_motor_open", door_motor_open, 1);
        door_open_req = 0; closed_limit = 0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (state !== 3'd1) bad = 1;
        end
        chk("norm_travel_hold", bad, 0);
        open_limit = 1;
        tick();
        chk("norm_dwell", state, 2);
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (state !== 3'd2) bad = 1;
        end
        chk("norm_dwell_15", bad, 0);
        tick();
        chk("norm_closing_16", state, 3);
        chk("norm_motor_close", door_motor_close, 1);
        open_limit = 0;
        repeat (3) tick();
        closed_limit = 1;
        tick();
        chk("norm_closed", state, 0);
        chk("norm_closed_ok", door_closed_ok, 1);

        // Interlock: open request while the car moves must not open the door.
        door_open_req = 1; motor_active = 1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (state !== 3'd0 || door_motor_open !== 1'b0) bad = 1;
        end
        chk("ilk_stay_closed", bad, 0);
        door_open_req = 0; motor_active = 0;

        // Obstruction: third reopen in a row latches FAULT.
        cycle_to_closing("obs1");
        obstruction = 1;
        tick();
        chk("obs1_reopen", state, 1);
        obstruction = 0; open_limit = 1;
        tick();
        repeat (15) tick();
        open_limit = 0;
        tick();
        chk("obs2_closing", state, 3);
        obstruction = 1;
        tick();
        chk("obs2_reopen", state, 1);
        obstruction = 0; open_limit = 1;
        tick();
        repeat (15) tick();
        open_limit = 0;
        tick();
        chk("obs3_closing", state, 3);
        obstruction = 1;
        tick();
        obstruction = 0;
        chk("obs3_fault", state, 4);
        chk("obs3_fault_flag", door_fault, 1);
        chk("obs3_motors", {door_motor_open, door_motor_close}, 0);
        door_open_req = 1; closed_limit = 1;
        repeat (5) tick();
        chk("obs_absorbing", state, 4);
        do_reset();
        tick();
        chk("obs_after_reset", state, 0);

        // Opening timeout: fault exactly 64 cycles after entry.
        door_open_req = 1;
        tick();
        door_open_req = 0; closed_limit = 0;
        repeat (63) tick();
        chk("to_63_opening", state, 1);
        tick();
        chk("to_64_fault", state, 4);
        do_reset();
        tick();

        // Variant: limit on the 64th cycle wins over the timeout.
        door_open_req = 1;
        tick();
        door_open_req = 0; closed_limit = 0;
        repeat (63) tick();
        open_limit = 1;
        tick();
        chk("to_limit_wins", state, 2);

        // Sensor conflict in OPEN_DWELL.
        tick();
        chk("conf_pre", state, 2);
        closed_limit = 1;
        tick();
        chk("conf_fault", state, 4);
        do_reset();
        tick();

        // Interlock violation while OPENING.
        door_open_req = 1;
        tick();
        motor_active = 1;
        tick();
        chk("ilk_opening_fault", state, 4);
        do_reset();
        tick();

        // Asynchronous reset mid-CLOSING, then re-close on the first edge.
        cycle_to_closing("rst");
        reset = 1'b1;
        #2;
        chk("async_rst_state", state, 0);
        chk("async_rst_ok", door_closed_ok, 1);
        tick();
        reset = 1'b0;
        tick();
        chk("rst_reclose", state, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
